// File: rtl/commit_controller_pkg.sv
// Shared encodings for the in-order commit sequencer: head entry types and FSM state.
package commit_controller_pkg;

  localparam logic [1:0] COMMIT_REG    = 2'd0;
  localparam logic [1:0] COMMIT_STORE  = 2'd1;
  localparam logic [1:0] COMMIT_BRANCH = 2'd2;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RETIRE     = 2'd1,
    STORE_WAIT = 2'd2,
    FLUSH      = 2'd3
  } commit_state_t;

endpackage

// File: rtl/commit_controller.sv
// In-order retirement sequencer: ROB head -> register-file update, store handshake or flush.
// Optional retired-instruction counter enabled by defining COMMIT_COUNTER_EN.
//
// state      | meaning
// IDLE       | sample ROB head; accept when valid and ready
// RETIRE     | one-cycle pop, plus reg write when dest != x0
// STORE_WAIT | storeReq held until storeAck
// FLUSH      | one-cycle flush strobe, optional link write, no pop
module commit_controller
  import commit_controller_pkg::*;
#(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clockIn,
  input  logic                 resetIn,
  input  logic                 headValid,
  input  logic                 headReady,
  input  logic [1:0]           headType,
  input  logic [4:0]           headDest,
  input  logic [31:0]          headValue,
  input  logic [ROB_WIDTH-1:0] headRobId,
  input  logic                 headMispredict,
  input  logic [31:0]          headTarget,
  output logic                 robPop,
  output logic                 regUpdateValid,
  output logic [4:0]           regUpdateDest,
  output logic [31:0]          regUpdateValue,
  output logic [ROB_WIDTH-1:0] regUpdateRobId,
  output logic                 storeReq,
  input  logic                 storeAck,
  output logic                 flushOut,
  output logic [31:0]          flushPc,
  output logic [31:0]          commitCount
);

  commit_state_t state, stateNext;
  logic popNext, writeNext, storeNext, flushNext, capture;
  logic [4:0]           destQ;
  logic [31:0]          valueQ;
  logic [ROB_WIDTH-1:0] robIdQ;
  logic [31:0]          targetQ;

  always_comb begin
    stateNext = state;
    popNext   = 1'b0;
    writeNext = 1'b0;
    storeNext = 1'b0;
    flushNext = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (headValid && headReady) begin
          capture = 1'b1;
          case (headType)
            COMMIT_STORE: begin
              stateNext = STORE_WAIT;
              storeNext = 1'b1;
            end
            COMMIT_BRANCH: begin
              if (headMispredict) begin
                stateNext = FLUSH;
                flushNext = 1'b1;
              end else begin
                stateNext = RETIRE;
                popNext   = 1'b1;
              end
              writeNext = (headDest != 5'd0);
            end
            default: begin
              stateNext = RETIRE;
              popNext   = 1'b1;
              writeNext = (headDest != 5'd0);
            end
          endcase
        end
      end
      STORE_WAIT: begin
        // Stores never write the register file, even on the retire cycle.
        if (storeAck) begin
          stateNext = RETIRE;
          popNext   = 1'b1;
        end else begin
          storeNext = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      state          <= IDLE;
      robPop         <= 1'b0;
      regUpdateValid <= 1'b0;
      storeReq       <= 1'b0;
      flushOut       <= 1'b0;
      destQ          <= '0;
      valueQ         <= '0;
      robIdQ         <= '0;
      targetQ        <= '0;
    end else begin
      state          <= stateNext;
      robPop         <= popNext;
      regUpdateValid <= writeNext;
      storeReq       <= storeNext;
      flushOut       <= flushNext;
      if (capture) begin
        destQ   <= headDest;
        valueQ  <= headValue;
        robIdQ  <= headRobId;
        targetQ <= headTarget;
      end
    end
  end

  assign regUpdateDest  = destQ;
  assign regUpdateValue = valueQ;
  assign regUpdateRobId = robIdQ;
  assign flushPc        = targetQ;

`ifdef COMMIT_COUNTER_EN
  logic [31:0] countQ;
  always_ff @(posedge clockIn) begin
    if (resetIn)
      countQ <= '0;
    else if (robPop || flushOut)
      countQ <= countQ + 32'd1;
  end
  assign commitCount = countQ;
`else
  assign commitCount = '0;
`endif

endmodule

// File: tb/tb_commit_controller.sv
// Directed self-checking bench for commit_controller; inputs change and outputs are sampled 1ns after each rising edge.
module tb_commit_controller;

  logic        clockIn = 1'b0;
  logic        resetIn;
  logic        headValid, headReady, headMispredict, storeAck;
  logic [1:0]  headType;
  logic [4:0]  headDest;
  logic [31:0] headValue, headTarget;
  logic [3:0]  headRobId;
  logic        robPop, regUpdateValid, storeReq, flushOut;
  logic [4:0]  regUpdateDest;
  logic [31:0] regUpdateValue, flushPc, commitCount;
  logic [3:0]  regUpdateRobId;

  int passed = 0;
  int total  = 0;
  int retired = 0;

  always #5 clockIn = ~clockIn;

  commit_controller #(.ROB_WIDTH(4)) dut (
    .clockIn(clockIn), .resetIn(resetIn),
    .headValid(headValid), .headReady(headReady), .headType(headType),
    .headDest(headDest), .headValue(headValue), .headRobId(headRobId),
    .headMispredict(headMispredict), .headTarget(headTarget),
    .robPop(robPop), .regUpdateValid(regUpdateValid),
    .regUpdateDest(regUpdateDest), .regUpdateValue(regUpdateValue),
    .regUpdateRobId(regUpdateRobId), .storeReq(storeReq), .storeAck(storeAck),
    .flushOut(flushOut), .flushPc(flushPc), .commitCount(commitCount)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clockIn);
    #1;
  endtask

  task automatic head(input logic [1:0] t, input logic [4:0] d, input logic [31:0] v,
                      input logic [3:0] id, input logic mis, input logic [31:0] tgt);
    headValid = 1'b1; headReady = 1'b1; headType = t; headDest = d;
    headValue = v; headRobId = id; headMispredict = mis; headTarget = tgt;
  endtask

  function automatic logic [31:0] exp_count(input int n);
`ifdef COMMIT_COUNTER_EN
    return 32'(n);
`else
    return 32'd0;
`endif
  endfunction

  initial begin
    resetIn = 1'b1; headValid = 1'b0; headReady = 1'b0; headType = 2'd0;
    headDest = 5'd0; headValue = 32'd0; headRobId = 4'd0; headMispredict = 1'b0;
    headTarget = 32'd0; storeAck = 1'b0;
    step(); step();
    check("rst_pop", {31'd0, robPop}, 32'd0);
    check("rst_wr", {31'd0, regUpdateValid}, 32'd0);
    check("rst_sreq", {31'd0, storeReq}, 32'd0);
    check("rst_flush", {31'd0, flushOut}, 32'd0);
    check("rst_dest", {27'd0, regUpdateDest}, 32'd0);
    check("rst_flushpc", flushPc, 32'd0);
    check("rst_count", commitCount, 32'd0);
    resetIn = 1'b0;

    // valid but not ready: nothing happens
    head(2'd0, 5'd4, 32'h11, 4'd1, 1'b0, 32'd0);
    headReady = 1'b0;
    step();
    check("notready_pop", {31'd0, robPop}, 32'd0);
    headValid = 1'b0;

    // plain register write
    head(2'd0, 5'd5, 32'hDEADBEEF, 4'd3, 1'b0, 32'd0);
    step();
    headValid = 1'b0; headDest = 5'd9; headValue = 32'h0;
    check("reg_pop", {31'd0, robPop}, 32'd1);
    check("reg_wr", {31'd0, regUpdateValid}, 32'd1);
    check("reg_dest", {27'd0, regUpdateDest}, 32'd5);
    check("reg_value", regUpdateValue, 32'hDEADBEEF);
    check("reg_robid", {28'd0, regUpdateRobId}, 32'd3);
    step();
    retired++;
    check("reg_pop_off", {31'd0, robPop}, 32'd0);
    check("reg_wr_off", {31'd0, regUpdateValid}, 32'd0);

    // write to x0 pops but never writes
    head(2'd0, 5'd0, 32'h1234, 4'd4, 1'b0, 32'd0);
    step();
    headValid = 1'b0;
    check("x0_pop", {31'd0, robPop}, 32'd1);
    check("x0_wr", {31'd0, regUpdateValid}, 32'd0);
    step();
    retired++;

    // storeAck outside STORE_WAIT is ignored
    storeAck = 1'b1;
    step();
    check("stray_ack_pop", {31'd0, robPop}, 32'd0);
    check("stray_ack_sreq", {31'd0, storeReq}, 32'd0);
    storeAck = 1'b0;

    // store with a three-cycle ack delay
    head(2'd1, 5'd7, 32'h55, 4'd5, 1'b0, 32'd0);
    step();
    headValid = 1'b0;
    check("st_req1", {31'd0, storeReq}, 32'd1);
    check("st_pop1", {31'd0, robPop}, 32'd0);
    step();
    check("st_req2", {31'd0, storeReq}, 32'd1);
    step();
    check("st_req3", {31'd0, storeReq}, 32'd1);
    check("st_wr3", {31'd0, regUpdateValid}, 32'd0);
    storeAck = 1'b1;
    step();
    storeAck = 1'b0;
    check("st_req_off", {31'd0, storeReq}, 32'd0);
    check("st_pop", {31'd0, robPop}, 32'd1);
    check("st_wr", {31'd0, regUpdateValid}, 32'd0);
    step();
    retired++;
    check("st_pop_off", {31'd0, robPop}, 32'd0);

    // branch mispredict with link write to x1
    head(2'd2, 5'd1, 32'h104, 4'd6, 1'b1, 32'h200);
    step();
    headValid = 1'b0;
    check("mp_flush", {31'd0, flushOut}, 32'd1);
    check("mp_pc", flushPc, 32'h200);
    check("mp_wr", {31'd0, regUpdateValid}, 32'd1);
    check("mp_dest", {27'd0, regUpdateDest}, 32'd1);
    check("mp_value", regUpdateValue, 32'h104);
    check("mp_pop", {31'd0, robPop}, 32'd0);
    step();
    retired++;
    check("mp_flush_off", {31'd0, flushOut}, 32'd0);

    // correctly predicted branch with no link
    head(2'd2, 5'd0, 32'h300, 4'd7, 1'b0, 32'h400);
    step();
    headValid = 1'b0;
    check("br_pop", {31'd0, robPop}, 32'd1);
    check("br_wr", {31'd0, regUpdateValid}, 32'd0);
    check("br_flush", {31'd0, flushOut}, 32'd0);
    step();
    retired++;

    // reserved type behaves as register write
    head(2'd3, 5'd9, 32'hCAFE, 4'd8, 1'b0, 32'd0);
    step();
    headValid = 1'b0;
    check("rsv_wr", {31'd0, regUpdateValid}, 32'd1);
    check("rsv_dest", {27'd0, regUpdateDest}, 32'd9);
    step();
    retired++;
    check("count", commitCount, exp_count(retired));

    // reset in the middle of STORE_WAIT abandons the store
    head(2'd1, 5'd2, 32'h77, 4'd9, 1'b0, 32'd0);
    step();
    headValid = 1'b0;
    check("rs_req", {31'd0, storeReq}, 32'd1);
    resetIn = 1'b1; storeAck = 1'b1;
    step();
    resetIn = 1'b0; storeAck = 1'b0;
    check("rs_req_off", {31'd0, storeReq}, 32'd0);
    check("rs_pop", {31'd0, robPop}, 32'd0);
    check("rs_count", commitCount, 32'd0);
    step();
    check("rs_pop2", {31'd0, robPop}, 32'd0);
    check("rs_req2", {31'd0, storeReq}, 32'd0);
    // back in IDLE: a new head is accepted immediately
    head(2'd0, 5'd3, 32'hAB, 4'd2, 1'b0, 32'd0);
    step();
    headValid = 1'b0;
    check("rs_idle_pop", {31'd0, robPop}, 32'd1);
    check("rs_idle_value", regUpdateValue, 32'hAB);
    step();
    check("rs_count2", commitCount, exp_count(1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/commit_controller.md
# commit_controller

In-order retirement sequencer between the reorder buffer head and the register file write port. Each cycle it inspects the ROB head entry and, when the entry is ready, drives one register-file update, performs a store handshake with the memory side, or raises a pipeline flush on branch mispredict. It is the only driver of the register file's `regUpdate*` inputs and of the ROB pop strobe.

## Interface
Parameters:
- ROB_WIDTH, 4, ROB index width; must match the register file and ROB.

Ports:
- clockIn  in  1  system clock; single clock domain
- resetIn  in  1  synchronous, active-high reset
- headValid  in  1  ROB head entry exists
- headReady  in  1  head result computed
- headType  in  2  0 = reg write, 1 = store, 2 = branch/jump, 3 = reserved (treated as reg write)
- headDest  in  5  destination register
- headValue  in  32  result or link value
- headRobId  in  ROB_WIDTH  ROB index of head
- headMispredict  in  1  branch outcome differs from prediction
- headTarget  in  32  correct next PC for mispredict
- robPop  out  1  one-cycle strobe; ROB advances head at end of cycle
- regUpdateValid  out  1  register-file write strobe
- regUpdateDest  out  5
- regUpdateValue  out  32
- regUpdateRobId  out  ROB_WIDTH
- storeReq  out  1  request memory commit of head store
- storeAck  in  1  memory accepted store
- flushOut  out  1  one-cycle pipeline flush strobe
- flushPc  out  32  restart PC, valid with flushOut
- commitCount  out  32  retired-instruction count

## Operation
- FSM states: IDLE, RETIRE, STORE_WAIT, FLUSH. All outputs registered.
- IDLE, headValid && headReady sampled high:
  - type 0/3 -> RETIRE.
  - type 1 -> STORE_WAIT.
  - type 2, !headMispredict -> RETIRE.
  - type 2, headMispredict -> FLUSH.
  - Otherwise stay IDLE.
- RETIRE, one cycle: robPop = 1. regUpdateValid = 1 iff the entry is type 0/2/3 and headDest != 0. Dest/value/robId are copied from the head as latched in IDLE. Next state IDLE.
- STORE_WAIT: storeReq held high. On the cycle storeAck is sampled high, go to RETIRE with regUpdateValid forced 0. storeReq deasserts in that RETIRE cycle.
- FLUSH, one cycle: flushOut = 1, flushPc = latched headTarget. regUpdateValid = 1 iff headDest != 0 (link write). robPop = 0, because the ROB clears on flushOut. Next state IDLE.
- Head fields are latched on the IDLE->X transition. Later changes on head inputs are ignored until the FSM returns to IDLE.
- Writes to x0 are never emitted.
- headValid dropping while in STORE_WAIT/RETIRE/FLUSH is ignored; the latched entry completes.

## Timing
- Reset values: state IDLE; robPop, regUpdateValid, storeReq, flushOut = 0; regUpdateDest, regUpdateValue, regUpdateRobId, flushPc = 0; commitCount = 0.
- Head ready sampled at edge N -> strobes high during cycle N+1 for exactly one cycle.
- Store: storeAck at edge M -> robPop high in cycle M+1.
- Maximum throughput is one retirement per 2 cycles, because the head is re-sampled only in IDLE, after the pop has taken effect.
- Reset asserted mid STORE_WAIT or FLUSH: all outputs return to reset values after the edge. No pop and no write are issued for the abandoned entry.
- storeAck high outside STORE_WAIT is ignored.

## Configuration
- COMMIT_COUNTER_EN defined: commitCount increments by 1 (wraps mod 2^32) on every cycle robPop = 1 or flushOut = 1.
- Not defined: commitCount is tied to 0 and the counter register is omitted. The port exists in both builds.

## Structure
- Shared package holds:
  - headType encodings (COMMIT_REG, COMMIT_STORE, COMMIT_BRANCH).
  - The 2-bit state encoding (IDLE/RETIRE/STORE_WAIT/FLUSH).
- Single flat module. No sub-module is natural; the optional counter is inline.

## Test plan
- Reg write: headType 0, dest 5, value 0xDEADBEEF, robId 3, ready at edge 1 -> cycle 2 shows regUpdateValid = 1, dest 5, value 0xDEADBEEF, robId 3, robPop = 1; both 0 in cycle 3.
- x0 write: headType 0, dest 0 -> robPop = 1, regUpdateValid = 0.
- Store with 3-cycle ack delay -> storeReq high 3 cycles; robPop = 1 the cycle after storeAck; regUpdateValid never 1.
- Mispredict: type 2, dest 1, value 0x104, target 0x200 -> flushOut = 1, flushPc = 0x200, regUpdateValid = 1 to x1 with 0x104, robPop = 0.
- Reset mid STORE_WAIT -> storeReq = 0 next cycle; no robPop; state IDLE.
- COMMIT_COUNTER_EN: 4 reg commits plus 1 flush -> commitCount = 5. Without the macro -> commitCount = 0.
